agu_multi: RTL and testbench

Parametrised multi-pointer address generation unit, the successor of the single-counter AGU. Holds NPTR address pointers, each byte-loadable from the data bus or word-loadable from the address bus, and steps them by a signed stride under CPU control or in a self-timed burst. Retains the address-capture latch with byte-lane readback onto the data bus. Sits between the CPU control sequencer and the memory address bus.

---
 rtl/agu_pkg.sv | 22 ++
 rtl/agu_ptr_file.sv | 111 +++++++++++
 rtl/agu_multi.sv | 145 ++++++++++++++
 tb/tb_agu_multi.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agu_pkg.sv
// agu_multi shared types: burst FSM states and the stride sign-extender.
// Optional window wrap is enabled with `define AGU_WRAP_EN.
package agu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } agu_state_t;

    // Sign-extend a dw-bit stride to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sext_step(input logic [63:0] s,
                                              input int unsigned dw);
        logic [63:0] r;
        r = s;
        for (int i = 0; i < 64; i++) begin
            if (i >= int'(dw)) r[i] = s[dw-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/agu_ptr_file.sv
// agu_multi pointer file: NPTR pointers, word/lane load ports, one step port.
// With AGU_WRAP_EN a lo/hi window replaces modulo wrap on steps.
module agu_ptr_file
    import agu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NPTR   = 4,
    localparam int NLANE = ADDR_W / DATA_W,
    localparam int PW    = $clog2(NPTR),
    localparam int LW    = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wa_en,
    input  logic [PW-1:0]     i_wa_sel,
    input  logic [ADDR_W-1:0] i_wa_data,
    input  logic              i_wb_en,
    input  logic [PW-1:0]     i_wb_sel,
    input  logic [LW-1:0]     i_wb_lane,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_st_en,
    input  logic [PW-1:0]     i_st_sel,
    input  logic [DATA_W-1:0] i_st_stride,
`ifdef AGU_WRAP_EN
    input  logic              i_lo_we,
    input  logic              i_hi_we,
    input  logic [ADDR_W-1:0] i_win_data,
`endif
    input  logic [PW-1:0]     i_rd_sel,
    output logic [ADDR_W-1:0] o_rd_data,
    output logic              o_cy
);

    localparam int SW = ADDR_W + 2;

    logic [ADDR_W-1:0] r_ptr [NPTR];
    logic              r_cy;
    logic [ADDR_W-1:0] w_cur;
    logic [SW-1:0]     w_sx;
    logic [ADDR_W:0]   w_add;
    logic [SW-1:0]     w_true;
    logic              w_neg;
    logic              w_fire;
    logic [ADDR_W-1:0] w_nxt;
    logic              w_cyr;

`ifdef AGU_WRAP_EN
    logic [ADDR_W-1:0] r_lo;
    logic [ADDR_W-1:0] r_hi;

    // Window bounds, loaded from the address bus
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lo <= '0;
            r_hi <= '1;
        end else begin
            if (i_lo_we) r_lo <= i_win_data;
            if (i_hi_we) r_hi <= i_win_data;
        end
    end
`endif

    assign w_cur  = r_ptr[i_st_sel];
    assign w_sx   = SW'(sext_step(64'(i_st_stride), DATA_W));
    assign w_neg  = i_st_stride[DATA_W-1];
    assign w_add  = {1'b0, w_cur} + {1'b0, w_sx[ADDR_W-1:0]};
    assign w_true = {2'b00, w_cur} + w_sx;
    assign w_fire = i_st_en
                  && !(i_wa_en && i_wa_sel == i_st_sel)
                  && !(i_wb_en && i_wb_sel == i_st_sel);

    // Step result; a negative stride borrows when no carry comes out
    always_comb begin
        w_nxt = w_add[ADDR_W-1:0];
        w_cyr = w_neg ? ~w_add[ADDR_W] : w_add[ADDR_W];
`ifdef AGU_WRAP_EN
        if (!w_neg && i_st_stride != '0
            && w_true > {2'b00, r_hi}) begin
            w_nxt = r_lo;
            w_cyr = 1'b0;
        end else if (w_neg
            && $signed(w_true) < $signed({2'b00, r_lo})) begin
            w_nxt = r_hi;
            w_cyr = 1'b0;
        end
`endif
    end

    // Per-pointer update: word load, then lane load, then step
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NPTR; i++) r_ptr[i] <= '0;
            r_cy <= 1'b0;
        end else begin
            for (int i = 0; i < NPTR; i++) begin
                if (i_wa_en && i_wa_sel == PW'(i))
                    r_ptr[i] <= i_wa_data;
                else if (i_wb_en && i_wb_sel == PW'(i))
                    r_ptr[i][int'(i_wb_lane)*DATA_W +: DATA_W] <= i_wb_data;
                else if (i_st_en && i_st_sel == PW'(i))
                    r_ptr[i] <= w_nxt;
            end
            r_cy <= w_fire && w_cyr;
        end
    end

    assign o_rd_data = r_ptr[i_rd_sel];
    assign o_cy      = r_cy;

endmodule

// File: rtl/agu_multi.sv
// agu_multi top: burst FSM, address latch with lane readback, pointer file.
// Define AGU_WRAP_EN to add wlo/whi window-wrap inputs.
module agu_multi
    import agu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NPTR   = 4,
    localparam int NLANE = ADDR_W / DATA_W,
    localparam int PW    = $clog2(NPTR),
    localparam int LW    = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PW-1:0]     psel,
    input  logic [LW-1:0]     lane,
    input  logic [ADDR_W-1:0] abi,
    input  logic [DATA_W-1:0] dbi,
    input  logic              cwa,
    input  logic              cwb,
    input  logic              cre,
    input  logic [DATA_W-1:0] step,
    input  logic              bst,
    input  logic              dwe,
    input  logic              drd,
`ifdef AGU_WRAP_EN
    input  logic              wlo,
    input  logic              whi,
`endif
    output logic [ADDR_W-1:0] abo,
    output logic [DATA_W-1:0] dbo,
    output logic              busy,
    output logic              done,
    output logic              cy
);

    agu_state_t        r_state;
    logic [PW-1:0]     r_bptr;
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_stride;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_latch;
    logic              w_in_burst;
    logic              w_st_en;
    logic [PW-1:0]     w_st_sel;
    logic [DATA_W-1:0] w_st_stride;
    logic [DATA_W-1:0] w_dbo;

    assign w_in_burst  = (r_state == BURST);
    assign w_st_en     = w_in_burst || cre;
    assign w_st_sel    = w_in_burst ? r_bptr : psel;
    assign w_st_stride = w_in_burst ? r_stride : step;

    // Burst sequencer: IDLE -> BURST (cnt steps) -> DONE (one pulse) -> IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_bptr   <= '0;
            r_cnt    <= '0;
            r_stride <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bst) begin
                        r_bptr   <= psel;
                        r_cnt    <= dbi;
                        r_stride <= step;
                        if (dbi == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= BURST;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    r_cnt <= r_cnt - DATA_W'(1);
                    if (r_cnt == DATA_W'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Address capture latch
    always_ff @(posedge clk) begin
        if (!rst) r_latch <= '0;
        else if (dwe) r_latch <= abi;
    end

    // Lane readback from the latch, zero when not reading
    always_comb begin
        w_dbo = '0;
        if (drd) w_dbo = r_latch[int'(lane)*DATA_W +: DATA_W];
    end

    agu_ptr_file #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NPTR   (NPTR)
    ) u_ptr (
        .clk         (clk),
        .rst         (rst),
        .i_wa_en     (cwa),
        .i_wa_sel    (psel),
        .i_wa_data   (abi),
        .i_wb_en     (cwb),
        .i_wb_sel    (psel),
        .i_wb_lane   (lane),
        .i_wb_data   (dbi),
        .i_st_en     (w_st_en),
        .i_st_sel    (w_st_sel),
        .i_st_stride (w_st_stride),
`ifdef AGU_WRAP_EN
        .i_lo_we     (wlo),
        .i_hi_we     (whi),
        .i_win_data  (abi),
`endif
        .i_rd_sel    (psel),
        .o_rd_data   (abo),
        .o_cy        (cy)
    );

    assign dbo  = w_dbo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_agu_multi.sv
// Directed bench for agu_multi, one task per scenario.
// Window-wrap scenario runs only when AGU_WRAP_EN is defined.
module tb_agu_multi;

    logic        clk;
    logic        rst;
    logic [1:0]  psel;
    logic        lane;
    logic [15:0] abi;
    logic [7:0]  dbi;
    logic        cwa;
    logic        cwb;
    logic        cre;
    logic [7:0]  step;
    logic        bst;
    logic        dwe;
    logic        drd;
`ifdef AGU_WRAP_EN
    logic        wlo;
    logic        whi;
`endif
    logic [15:0] abo;
    logic [7:0]  dbo;
    logic        busy;
    logic        done;
    logic        cy;

    int errors = 0;
    int checks = 0;

    agu_multi #(.ADDR_W(16), .DATA_W(8), .NPTR(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .psel (psel),
        .lane (lane),
        .abi  (abi),
        .dbi  (dbi),
        .cwa  (cwa),
        .cwb  (cwb),
        .cre  (cre),
        .step (step),
        .bst  (bst),
        .dwe  (dwe),
        .drd  (drd),
`ifdef AGU_WRAP_EN
        .wlo  (wlo),
        .whi  (whi),
`endif
        .abo  (abo),
        .dbo  (dbo),
        .busy (busy),
        .done (done),
        .cy   (cy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cwa = 0; cwb = 0; cre = 0; bst = 0;
        dwe = 0; drd = 0; step = 0; dbi = 0;
        abi = 0; lane = 0;
`ifdef AGU_WRAP_EN
        wlo = 0; whi = 0;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        psel = 0;
        rst = 0;
        tick();
        tick();
        rst = 1;
        drd = 1;
        #1;
        checks++;
        if (abo !== 16'h0) begin
            errors++;
            $display("FAIL reset_abo: got %h want 0000", abo);
        end
        checks++;
        if (dbo !== 8'h0) begin
            errors++;
            $display("FAIL reset_dbo: got %h want 00", dbo);
        end
        checks++;
        if ({busy, done, cy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, cy});
        end
        drd = 0;
    endtask

    task automatic test_byte_load();
        psel = 0;
        cwb = 1; lane = 0; dbi = 8'd100;
        tick();
        lane = 1; dbi = 8'd64;
        tick();
        cwb = 0; lane = 0;
        checks++;
        if (abo !== 16'h4064) begin
            errors++;
            $display("FAIL byte_load: got %h want 4064", abo);
        end
        cre = 1; step = 8'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cy !== 1'b0) begin
                errors++;
                $display("FAIL step_nocy: cycle %0d got %b want 0", i, cy);
            end
        end
        cre = 0;
        checks++;
        if (abo !== 16'h4067) begin
            errors++;
            $display("FAIL step_up: got %h want 4067", abo);
        end
    endtask

    task automatic test_wrap_cy();
        psel = 1;
        cwa = 1; abi = 16'h0000;
        tick();
        cwa = 0;
        cre = 1; step = 8'hFF;
        tick();
        cre = 0;
        checks++;
        if (abo !== 16'hFFFF || cy !== 1'b1) begin
            errors++;
            $display("FAIL borrow: got %h/%b want ffff/1", abo, cy);
        end
        tick();
        checks++;
        if (cy !== 1'b0) begin
            errors++;
            $display("FAIL borrow_pulse: got %b want 0", cy);
        end
        cre = 1; step = 8'h01;
        tick();
        cre = 0;
        checks++;
        if (abo !== 16'h0000 || cy !== 1'b1) begin
            errors++;
            $display("FAIL carry: got %h/%b want 0000/1", abo, cy);
        end
        tick();
        checks++;
        if (cy !== 1'b0) begin
            errors++;
            $display("FAIL carry_pulse: got %b want 0", cy);
        end
    endtask

    task automatic test_priority();
        psel = 3;
        cwa = 1; abi = 16'h0500;
        cwb = 1; lane = 0; dbi = 8'hAA;
        cre = 1; step = 8'h01;
        tick();
        checks++;
        if (abo !== 16'h0500 || cy !== 1'b0) begin
            errors++;
            $display("FAIL prio_word: got %h/%b want 0500/0", abo, cy);
        end
        cwa = 0;
        tick();
        cwb = 0; cre = 0;
        checks++;
        if (abo !== 16'h05AA) begin
            errors++;
            $display("FAIL prio_lane: got %h want 05aa", abo);
        end
    endtask

    task automatic test_latch();
        dwe = 1; abi = 16'h7A0E;
        drd = 1; lane = 0;
        #1;
        checks++;
        if (dbo !== 8'h00) begin
            errors++;
            $display("FAIL latch_old0: got %h want 00", dbo);
        end
        tick();
        dwe = 0; abi = 0;
        #1;
        checks++;
        if (dbo !== 8'h0E) begin
            errors++;
            $display("FAIL latch_lane0: got %h want 0e", dbo);
        end
        lane = 1;
        #1;
        checks++;
        if (dbo !== 8'h7A) begin
            errors++;
            $display("FAIL latch_lane1: got %h want 7a", dbo);
        end
        drd = 0;
        #1;
        checks++;
        if (dbo !== 8'h00) begin
            errors++;
            $display("FAIL latch_nodrd: got %h want 00", dbo);
        end
        dwe = 1; abi = 16'h1234; drd = 1; lane = 0;
        #1;
        checks++;
        if (dbo !== 8'h0E) begin
            errors++;
            $display("FAIL latch_rdwr: got %h want 0e", dbo);
        end
        tick();
        dwe = 0;
        #1;
        checks++;
        if (dbo !== 8'h34) begin
            errors++;
            $display("FAIL latch_new: got %h want 34", dbo);
        end
        drd = 0; lane = 0;
    endtask

    task automatic test_burst();
        psel = 2;
        cwa = 1; abi = 16'h1000;
        tick();
        cwa = 0;
        bst = 1; dbi = 8'd4; step = 8'd2;
        tick();
        bst = 0; dbi = 0;
        psel = 0; cre = 1; step = 8'd5;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL burst_busy: cycle %0d got %b%b want 10",
                         i, busy, done);
            end
            tick();
        end
        cre = 0; step = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL burst_done: got %b%b want 01", busy, done);
        end
        checks++;
        if (abo !== 16'h4067) begin
            errors++;
            $display("FAIL burst_cre_ign: got %h want 4067", abo);
        end
        psel = 2;
        #1;
        checks++;
        if (abo !== 16'h1008) begin
            errors++;
            $display("FAIL burst_ptr: got %h want 1008", abo);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: got %b%b want 00", busy, done);
        end
    endtask

    task automatic test_zero_burst();
        psel = 1;
        bst = 1; dbi = 8'd0; step = 8'd3;
        tick();
        bst = 0; step = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_burst: got %b%b want 01", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || abo !== 16'h0000) begin
            errors++;
            $display("FAIL zero_after: got %b/%h want 0/0000", done, abo);
        end
    endtask

    task automatic test_burst_reset();
        psel = 2;
        bst = 1; dbi = 8'd4; step = 8'd2;
        tick();
        bst = 0; dbi = 0; step = 0;
        tick();
        rst = 0;
        tick();
        rst = 1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || abo !== 16'h0000) begin
            errors++;
            $display("FAIL burst_rst: got %b%b/%h want 00/0000",
                     busy, done, abo);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL burst_rst_nodone: cycle %0d got %b%b want 00",
                         i, busy, done);
            end
        end
    endtask

`ifdef AGU_WRAP_EN
    task automatic test_window();
        wlo = 1; abi = 16'h2000;
        tick();
        wlo = 0; whi = 1; abi = 16'h2003;
        tick();
        whi = 0;
        psel = 0; cwa = 1; abi = 16'h2003;
        tick();
        cwa = 0;
        cre = 1; step = 8'h01;
        tick();
        cre = 0;
        checks++;
        if (abo !== 16'h2000 || cy !== 1'b0) begin
            errors++;
            $display("FAIL win_up: got %h/%b want 2000/0", abo, cy);
        end
        cre = 1; step = 8'hFF;
        tick();
        cre = 0;
        checks++;
        if (abo !== 16'h2003 || cy !== 1'b0) begin
            errors++;
            $display("FAIL win_down: got %h/%b want 2003/0", abo, cy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_byte_load();
        test_wrap_cy();
        test_priority();
        test_latch();
        test_burst();
        test_zero_burst();
        test_burst_reset();
`ifdef AGU_WRAP_EN
        test_window();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
